// File: rtl/window_mask_scanner.sv
// window_mask_scanner
// Scans addresses 0..2^ADDR_W-1 once per trigger (or continuously) and emits,
// one cycle after each address, a registered per-channel in-window bit plus a
// per-channel valid. Each channel holds its own [start,end] window in a shadow
// register; position updates arriving mid-scan are staged and only applied at
// a frame boundary so a frame never mixes two window sets.

module window_mask_scanner #(
    parameter int CH_NUM = 3,
    parameter int ADDR_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CH_NUM*ADDR_W-1:0]   start_pos,
    input  logic [CH_NUM*ADDR_W-1:0]   end_pos,
    input  logic                       pos_load,
    input  logic                       wrap_en,
    input  logic [CH_NUM-1:0]          ch_err,
    input  logic                       scan_trig,
    input  logic                       cont_mode,
    input  logic                       scan_abort,
    output logic                       rd_en,
    output logic [ADDR_W-1:0]          rd_addr,
    output logic [CH_NUM-1:0]          mask_out,
    output logic [CH_NUM-1:0]          mask_valid,
    output logic                       scan_done,
    output logic [CH_NUM-1:0]          cfg_err,
    output logic                       busy
);

    localparam logic [0:0]        ST_IDLE   = 1'b0;
    localparam logic [0:0]        ST_SCAN   = 1'b1;
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    // Window membership for one channel. Returns the hit bit; a start>end
    // window only hits when wrapping is allowed.
    function automatic logic win_hit(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] s,
        input logic [ADDR_W-1:0] e,
        input logic              wrap
    );
        logic hit;
        if (s <= e) begin
            hit = (a >= s) && (a <= e);
        end else if (wrap) begin
            hit = (a >= s) || (a <= e);
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    // Configuration error for one channel: inverted window with wrap disabled.
    function automatic logic win_cfg_err(
        input logic [ADDR_W-1:0] s,
        input logic [ADDR_W-1:0] e,
        input logic              wrap
    );
        return (s > e) && !wrap;
    endfunction

    // State
    logic [0:0]               state_r;
    logic                     rd_en_r;
    logic [ADDR_W-1:0]        rd_addr_r;
    logic                     busy_r;
    logic [CH_NUM*ADDR_W-1:0] shadow_s_r;
    logic [CH_NUM*ADDR_W-1:0] shadow_e_r;
    logic [CH_NUM*ADDR_W-1:0] stage_s_r;
    logic [CH_NUM*ADDR_W-1:0] stage_e_r;
    logic                     loaded_r;
    logic                     pending_r;
    logic                     trig_d_r;
    logic [CH_NUM-1:0]        mask_out_r;
    logic [CH_NUM-1:0]        mask_valid_r;
    logic                     scan_done_r;

    // Decoded control
    logic                     is_scan_s;
    logic                     trig_edge_s;
    logic                     abort_s;
    logic                     last_s;
    logic                     start_s;
    logic                     wrap_s;
    logic                     end_s;
    logic                     apply_s;
    logic [CH_NUM-1:0]        in_win_s;
    logic [CH_NUM-1:0]        cfg_err_s;

    // Per-channel window hit at the current address and configuration check.
    always_comb begin
        in_win_s  = {CH_NUM{1'b0}};
        cfg_err_s = {CH_NUM{1'b0}};
        for (int i = 0; i < CH_NUM; i++) begin
            in_win_s[i]  = win_hit(rd_addr_r,
                                   shadow_s_r[i*ADDR_W +: ADDR_W],
                                   shadow_e_r[i*ADDR_W +: ADDR_W],
                                   wrap_en);
            cfg_err_s[i] = win_cfg_err(shadow_s_r[i*ADDR_W +: ADDR_W],
                                       shadow_e_r[i*ADDR_W +: ADDR_W],
                                       wrap_en);
        end
    end

    // Sequencing decisions; abort outranks both wrap and normal end-of-frame.
    always_comb begin
        is_scan_s   = (state_r == ST_SCAN);
        trig_edge_s = scan_trig & ~trig_d_r;
        abort_s     = is_scan_s & scan_abort;
        last_s      = is_scan_s & (rd_addr_r == ADDR_LAST);
        start_s     = ~is_scan_s & trig_edge_s & (loaded_r | pos_load);
        wrap_s      = last_s & cont_mode & ~abort_s;
        end_s       = abort_s | (last_s & ~cont_mode);
        apply_s     = wrap_s | end_s;
    end

    // Trigger history for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_d_r <= 1'b0;
        end else begin
            trig_d_r <= scan_trig;
        end
    end

    // Scan FSM: state, address counter and address-valid flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            rd_en_r   <= 1'b0;
            rd_addr_r <= ADDR_ZERO;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r   <= ST_SCAN;
                        rd_en_r   <= 1'b1;
                        rd_addr_r <= ADDR_ZERO;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        rd_en_r   <= 1'b0;
                        rd_addr_r <= ADDR_ZERO;
                        busy_r    <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (end_s) begin
                        state_r   <= ST_IDLE;
                        rd_en_r   <= 1'b0;
                        rd_addr_r <= ADDR_ZERO;
                        busy_r    <= 1'b0;
                    end else if (wrap_s) begin
                        state_r   <= ST_SCAN;
                        rd_en_r   <= 1'b1;
                        rd_addr_r <= ADDR_ZERO;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= ST_SCAN;
                        rd_en_r   <= 1'b1;
                        rd_addr_r <= rd_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        busy_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    rd_en_r   <= 1'b0;
                    rd_addr_r <= ADDR_ZERO;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    // Window positions: direct load while idle, staged load while scanning,
    // staged values promoted at the frame boundary (a same-cycle load wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_s_r <= {(CH_NUM*ADDR_W){1'b0}};
            shadow_e_r <= {(CH_NUM*ADDR_W){1'b0}};
            stage_s_r  <= {(CH_NUM*ADDR_W){1'b0}};
            stage_e_r  <= {(CH_NUM*ADDR_W){1'b0}};
            loaded_r   <= 1'b0;
            pending_r  <= 1'b0;
        end else if (!is_scan_s) begin
            if (pos_load) begin
                shadow_s_r <= start_pos;
                shadow_e_r <= end_pos;
                loaded_r   <= 1'b1;
            end else begin
                shadow_s_r <= shadow_s_r;
                shadow_e_r <= shadow_e_r;
                loaded_r   <= loaded_r;
            end
            pending_r <= 1'b0;
        end else if (apply_s) begin
            if (pos_load) begin
                shadow_s_r <= start_pos;
                shadow_e_r <= end_pos;
            end else if (pending_r) begin
                shadow_s_r <= stage_s_r;
                shadow_e_r <= stage_e_r;
            end else begin
                shadow_s_r <= shadow_s_r;
                shadow_e_r <= shadow_e_r;
            end
            pending_r <= 1'b0;
        end else if (pos_load) begin
            stage_s_r <= start_pos;
            stage_e_r <= end_pos;
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Registered mask/valid for the address presented this cycle; an abort
    // drops the in-flight entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_out_r   <= {CH_NUM{1'b0}};
            mask_valid_r <= {CH_NUM{1'b0}};
        end else if (abort_s) begin
            mask_out_r   <= {CH_NUM{1'b0}};
            mask_valid_r <= {CH_NUM{1'b0}};
        end else begin
            mask_out_r   <= in_win_s & ~ch_err & {CH_NUM{rd_en_r}};
            mask_valid_r <= {CH_NUM{rd_en_r}} & ~ch_err;
        end
    end

    // End-of-frame pulse aligned with the mask of the last address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_done_r <= 1'b0;
        end else begin
            scan_done_r <= rd_en_r & (rd_addr_r == ADDR_LAST) & ~scan_abort;
        end
    end

    assign rd_en      = rd_en_r;
    assign rd_addr    = rd_addr_r;
    assign busy       = busy_r;
    assign mask_out   = mask_out_r;
    assign mask_valid = mask_valid_r;
    assign scan_done  = scan_done_r;
    assign cfg_err    = cfg_err_s;

endmodule

// File: tb/tb_window_mask_scanner.sv
// Directed bench for window_mask_scanner (CH_NUM=3, ADDR_W=8).
module tb_window_mask_scanner;

    logic        clk;
    logic        rst_n;
    logic [23:0] start_pos;
    logic [23:0] end_pos;
    logic        pos_load;
    logic        wrap_en;
    logic [2:0]  ch_err;
    logic        scan_trig;
    logic        cont_mode;
    logic        scan_abort;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [2:0]  mask_out;
    logic [2:0]  mask_valid;
    logic        scan_done;
    logic [2:0]  cfg_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    window_mask_scanner #(.CH_NUM(3), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_pos(start_pos), .end_pos(end_pos),
        .pos_load(pos_load), .wrap_en(wrap_en), .ch_err(ch_err),
        .scan_trig(scan_trig), .cont_mode(cont_mode), .scan_abort(scan_abort),
        .rd_en(rd_en), .rd_addr(rd_addr), .mask_out(mask_out),
        .mask_valid(mask_valid), .scan_done(scan_done), .cfg_err(cfg_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rng(input int lo, input int hi);
        logic [255:0] r;
        r = '0;
        for (int a = lo; a <= hi; a++) r[a] = 1'b1;
        return r;
    endfunction

    function automatic logic [23:0] pack3(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
        return {c2, c1, c0};
    endfunction

    task automatic load(input logic [23:0] s, input logic [23:0] e);
        start_pos = s;
        end_pos   = e;
        pos_load  = 1'b1;
        step();
        pos_load  = 1'b0;
    endtask

    task automatic trig_edge();
        scan_trig = 1'b0;
        step();
        scan_trig = 1'b1;
        step();
    endtask

    // Called at the negedge right after scan start (rd_addr==0 presented).
    task automatic run_frame(input logic [255:0] m0, input logic [255:0] m1,
                             input logic [255:0] m2, input logic [255:0] err1,
                             input bit cont, input int pl_at,
                             input logic [23:0] pl_s, input logic [23:0] pl_e,
                             input int trig_at);
        int a;
        chk("frame_rd_en0", {31'd0, rd_en}, 32'd1);
        chk("frame_addr0", {24'd0, rd_addr}, 32'd0);
        chk("frame_busy0", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 256; k++) begin
            a = k - 1;
            ch_err   = {1'b0, err1[a], 1'b0};
            pos_load = (a == pl_at);
            if (a == pl_at) begin
                start_pos = pl_s;
                end_pos   = pl_e;
            end
            if (trig_at >= 0 && a == trig_at)     scan_trig = 1'b0;
            if (trig_at >= 0 && a == trig_at + 1) scan_trig = 1'b1;
            step();
            chk("mask_valid", {29'd0, mask_valid}, {29'd0, 1'b1, ~err1[a], 1'b1});
            chk("mask_out", {29'd0, mask_out}, {29'd0, m2[a], m1[a] & ~err1[a], m0[a]});
            chk("scan_done", {31'd0, scan_done}, {31'd0, (k == 256)});
            if (k < 256 || cont) begin
                chk("rd_en_run", {31'd0, rd_en}, 32'd1);
                chk("rd_addr_run", {24'd0, rd_addr}, k % 256);
            end else begin
                chk("rd_en_end", {31'd0, rd_en}, 32'd0);
                chk("rd_addr_end", {24'd0, rd_addr}, 32'd0);
                chk("busy_end", {31'd0, busy}, 32'd0);
            end
        end
        pos_load = 1'b0;
        ch_err   = 3'b000;
    endtask

    initial begin
        rst_n = 1'b0; start_pos = '0; end_pos = '0; pos_load = 1'b0;
        wrap_en = 1'b0; ch_err = 3'b000; scan_trig = 1'b0; cont_mode = 1'b0;
        scan_abort = 1'b0;
        step();
        step();
        // Reset state
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_rd_addr", {24'd0, rd_addr}, 32'd0);
        chk("rst_mask_out", {29'd0, mask_out}, 32'd0);
        chk("rst_mask_valid", {29'd0, mask_valid}, 32'd0);
        chk("rst_scan_done", {31'd0, scan_done}, 32'd0);
        chk("rst_cfg_err", {29'd0, cfg_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        step();

        // Trigger without any prior load is ignored
        trig_edge();
        chk("noload_rd_en", {31'd0, rd_en}, 32'd0);
        chk("noload_busy", {31'd0, busy}, 32'd0);
        step();
        chk("noload_rd_en2", {31'd0, rd_en}, 32'd0);

        // Basic scan with ch_err on ch1 at 60..69 and a trigger edge mid-scan
        load(pack3(8'd10, 8'd0, 8'd255), pack3(8'd20, 8'd0, 8'd255));
        trig_edge();
        run_frame(rng(10, 20), rng(0, 0), rng(255, 255), rng(60, 69), 1'b0,
                  -1, 24'd0, 24'd0, 150);
        // Held-high trigger must not restart
        for (int i = 0; i < 4; i++) begin
            step();
            chk("held_trig_rd_en", {31'd0, rd_en}, 32'd0);
            chk("held_trig_done", {31'd0, scan_done}, 32'd0);
            chk("held_trig_valid", {29'd0, mask_valid}, 32'd0);
        end

        // Wrap-around window with wrap enabled
        wrap_en = 1'b1;
        load(pack3(8'd250, 8'd100, 8'd7), pack3(8'd5, 8'd100, 8'd9));
        chk("wrap_cfg_err", {29'd0, cfg_err}, 32'd0);
        trig_edge();
        run_frame(rng(250, 255) | rng(0, 5), rng(100, 100), rng(7, 9), '0, 1'b0,
                  -1, 24'd0, 24'd0, -1);

        // Same window with wrap disabled: configuration error, empty mask
        wrap_en = 1'b0;
        #1;
        chk("nowrap_cfg_err", {29'd0, cfg_err}, 32'd1);
        trig_edge();
        run_frame('0, rng(100, 100), rng(7, 9), '0, 1'b0, -1, 24'd0, 24'd0, -1);
        chk("nowrap_cfg_err2", {29'd0, cfg_err}, 32'd1);

        // Continuous mode with a staged update at address 100
        cont_mode = 1'b1;
        load(pack3(8'd10, 8'd0, 8'd255), pack3(8'd20, 8'd0, 8'd255));
        chk("cont_cfg_err", {29'd0, cfg_err}, 32'd0);
        trig_edge();
        run_frame(rng(10, 20), rng(0, 0), rng(255, 255), '0, 1'b1,
                  100, pack3(8'd30, 8'd0, 8'd255), pack3(8'd40, 8'd0, 8'd255), -1);
        cont_mode = 1'b0;
        run_frame(rng(30, 40), rng(0, 0), rng(255, 255), '0, 1'b0,
                  -1, 24'd0, 24'd0, -1);

        // Abort at address 50, with a staged update pending
        load(pack3(8'd10, 8'd0, 8'd255), pack3(8'd20, 8'd0, 8'd255));
        trig_edge();
        start_pos = pack3(8'd60, 8'd0, 8'd255);
        end_pos   = pack3(8'd70, 8'd0, 8'd255);
        for (int i = 0; i < 50; i++) begin
            pos_load = (i == 40);
            step();
        end
        pos_load = 1'b0;
        chk("abort_pre_addr", {24'd0, rd_addr}, 32'd50);
        chk("abort_pre_valid", {29'd0, mask_valid}, 32'd7);
        scan_abort = 1'b1;
        step();
        scan_abort = 1'b0;
        chk("abort_rd_en", {31'd0, rd_en}, 32'd0);
        chk("abort_rd_addr", {24'd0, rd_addr}, 32'd0);
        chk("abort_valid", {29'd0, mask_valid}, 32'd0);
        chk("abort_done", {31'd0, scan_done}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        step();
        chk("abort_done2", {31'd0, scan_done}, 32'd0);
        chk("abort_rd_en2", {31'd0, rd_en}, 32'd0);
        // Staged window applied at abort
        trig_edge();
        run_frame(rng(60, 70), rng(0, 0), rng(255, 255), '0, 1'b0,
                  -1, 24'd0, 24'd0, -1);

        // Asynchronous reset in mid-scan at address 128
        trig_edge();
        for (int i = 0; i < 128; i++) step();
        chk("prerst_addr", {24'd0, rd_addr}, 32'd128);
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("midrst_rd_addr", {24'd0, rd_addr}, 32'd0);
        chk("midrst_mask_out", {29'd0, mask_out}, 32'd0);
        chk("midrst_valid", {29'd0, mask_valid}, 32'd0);
        chk("midrst_done", {31'd0, scan_done}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        #1;
        rst_n = 1'b1;
        step();
        trig_edge();
        chk("postrst_rd_en", {31'd0, rd_en}, 32'd0);
        step();
        chk("postrst_busy", {31'd0, busy}, 32'd0);

        // pos_load and trigger edge in the same idle cycle
        scan_trig = 1'b0;
        step();
        start_pos = pack3(8'd5, 8'd0, 8'd255);
        end_pos   = pack3(8'd6, 8'd0, 8'd255);
        pos_load  = 1'b1;
        scan_trig = 1'b1;
        step();
        pos_load  = 1'b0;
        run_frame(rng(5, 6), rng(0, 0), rng(255, 255), '0, 1'b0,
                  -1, 24'd0, 24'd0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/window_mask_scanner.md
Name: window_mask_scanner

Overview:
- Parametrised successor to the three-channel select-RAM scan group.
- Holds an independent [start,end] window per channel and scans an address range 0..2^ADDR_W-1 once per trigger, or continuously.
- Emits a per-channel registered in-window mask bit with per-channel valid, aligned to the scan address.
- Adds per-channel positions, wrap-around windows, continuous mode, abort, double-buffered position load, and per-channel error masking. Feeds the downstream phase-window accumulators.

Parameters:
- CH_NUM, 3, number of window channels (1..16).
- ADDR_W, 8, scan address width; DEPTH = 2^ADDR_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start_pos  in  CH_NUM*ADDR_W  per-channel window start; channel i occupies bits [i*ADDR_W +: ADDR_W]
- end_pos  in  CH_NUM*ADDR_W  per-channel window end; same packing as start_pos
- pos_load  in  1  one-cycle pulse that loads start_pos/end_pos into shadow registers
- wrap_en  in  1  allows start>end windows to wrap around address 0
- ch_err  in  CH_NUM  per-channel error; forces that channel's mask and valid to 0
- scan_trig  in  1  level input; its rising edge starts a scan
- cont_mode  in  1  1 = restart automatically after the last address
- scan_abort  in  1  terminates an active scan
- rd_en  out  1  scan active / address valid
- rd_addr  out  ADDR_W  current scan address
- mask_out  out  CH_NUM  registered in-window bit per channel
- mask_valid  out  CH_NUM  per-channel valid for mask_out
- scan_done  out  1  one-cycle pulse coincident with the last mask of a frame
- cfg_err  out  CH_NUM  channel has start>end while wrap_en=0
- busy  out  1  FSM in SCAN

Behaviour:
- Reset values: every output 0, shadow positions 0, loaded flag 0, pending flag 0, trigger history register 0, FSM in IDLE.
- Trigger edge: scan_trig is sampled into trig_d every cycle; edge = scan_trig & ~trig_d.
- Shadow load in IDLE: pos_load copies inputs to shadow at the next edge and sets loaded.
- Shadow load in SCAN: pos_load captures inputs into a staging register and sets pending. Staging moves to shadow at the edge where rd_addr wraps DEPTH-1 -> 0 (continuous mode) or at the return to IDLE. A new pos_load while pending overwrites staging.
- Window rule per channel, using shadow s, e and address a:
  - s<=e: in = (a>=s) && (a<=e).
  - s>e and wrap_en=1: in = (a>=s) || (a<=e).
  - s>e and wrap_en=0: in = 0 and cfg_err[i] = 1.
  - cfg_err is combinational from shadow and wrap_en.
- FSM states IDLE and SCAN:
  - IDLE -> SCAN on edge && loaded. Outputs after that clock edge: rd_en=1, rd_addr=0, busy=1.
  - An edge while loaded=0 is ignored and produces no output.
  - SCAN: rd_addr increments by 1 every cycle.
  - At rd_addr = DEPTH-1 with cont_mode=1: rd_addr wraps to 0 and the FSM stays in SCAN.
  - At rd_addr = DEPTH-1 with cont_mode=0: go to IDLE, rd_en=0, rd_addr=0.
  - cont_mode is sampled only at the last address.
  - Trigger edges during SCAN are ignored.
- Latency: mask_out and mask_valid for address a appear exactly 1 cycle after rd_addr=a is presented with rd_en=1.
  - mask_valid[i] = registered (rd_en & ~ch_err[i]).
  - mask_out[i] = registered (in & ~ch_err[i]).
  - ch_err is sampled in the same cycle as the address.
- scan_done: registered copy of (rd_en && rd_addr==DEPTH-1 && !scan_abort). It pulses once per frame, also in continuous mode.
- Abort: scan_abort=1 in SCAN.
  - At the next edge: FSM -> IDLE, rd_en=0, rd_addr=0, mask_valid=0. The in-flight entry is dropped; scan_done is not pulsed.
  - Pending staging is applied at that edge.
  - scan_abort in IDLE has no effect.
- Abort and last address in the same cycle: abort wins (no scan_done, no wrap).
- pos_load and trigger edge in the same IDLE cycle: the shadow update and the SCAN entry happen at the same edge, and the scan uses the new positions. loaded counts as satisfied if either loaded=1 or pos_load=1 in that cycle.
- Mid-operation reset: everything returns to reset values immediately (asynchronous); loaded is cleared, so a pos_load is required before the next scan.

Test Plan:
- Basic scan: ADDR_W=8, ch0 window [10,20], ch1 [0,0], ch2 [255,255], pos_load, then scan_trig 0->1, cont_mode=0 -> 256 cycles of rd_en. ch0 mask=1 exactly for addresses 10..20 (11 bits); ch1 only address 0; ch2 only address 255. Single scan_done aligned with the mask of address 255; rd_en=0 afterwards.
- Wrap and cfg_err: ch0 window [250,5].
  - wrap_en=1 -> mask=1 for 250..255 and 0..5 (12 bits), cfg_err=0.
  - wrap_en=0 -> all-zero mask, cfg_err[0]=1.
- Continuous mode with double buffer: cont_mode=1, ch0 window [10,20]; pos_load [30,40] at address 100 -> frame 1 still uses 10..20, frame 2 uses 30..40. scan_done pulses at the end of each frame; rd_addr goes 255->0 with no gap.
- Abort: scan_abort at rd_addr=50 -> rd_en=0 and mask_valid=0 at the next edge, no scan_done.
- Trigger gating: scan_trig rising with no prior pos_load is ignored. A held-high trig does not retrigger after the scan. A trig edge during SCAN is ignored.
- ch_err: ch_err[1]=1 for addresses 60..69 -> mask_valid[1]=0 and mask_out[1]=0 for exactly those 10 outputs; other channels are unaffected.
- Reset: rst_n low at address 128 -> all outputs 0 immediately, and a following trig edge with no pos_load is ignored.
